// File: rtl/lcd_msg_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// lcd_msg_scheduler_pkg
// Shared definitions for the LCD status-screen scheduler: screen codes,
// FSM state encoding, request-vector layout and the fixed-priority helpers.
//
// Request vector layout (bit -> screen):
//   0 SELECT, 1 COIN, 2 PAY, 3 CHARGE, 4 NONENOUGH, 5 COIN_OV
// A higher bit index means a higher priority, and bit i maps to screen i+1.
// ---------------------------------------------------------------------------
package lcd_msg_scheduler_pkg;

  typedef enum logic [2:0] {
    MSG_IDLE      = 3'd0,
    MSG_SELECT    = 3'd1,
    MSG_COIN      = 3'd2,
    MSG_PAY       = 3'd3,
    MSG_CHARGE    = 3'd4,
    MSG_NONENOUGH = 3'd5,
    MSG_COIN_OV   = 3'd6
  } msg_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SHOW = 1'b1
  } state_e;

  localparam int NUM_REQ = 6;

  typedef logic [NUM_REQ-1:0] req_t;

  // Error screens (NONENOUGH, COIN_OV) are the two highest-priority requests.
  localparam req_t ERR_MASK = 6'b11_0000;

  // Highest-priority pending request wins; MSG_IDLE when nothing is pending.
  function automatic msg_e pick_winner(input req_t req);
    msg_e win;
    win = MSG_IDLE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) win = msg_e'(3'(i + 1));
    end
    return win;
  endfunction

  // One-hot request bit belonging to a screen (all zero for IDLE).
  function automatic req_t req_mask(input msg_e m);
    req_t mask;
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m == msg_e'(3'(i + 1))) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  function automatic logic is_error(input msg_e m);
    return (m == MSG_COIN_OV) || (m == MSG_NONENOUGH);
  endfunction

endpackage

// File: rtl/lcd_frame_tick.sv
// ---------------------------------------------------------------------------
// lcd_frame_tick
// Turns the LCD vsync level into a one-cycle frame boundary strobe.
// lcd_vs is registered once; the edge of the selected polarity between the
// live input and that register is itself registered, so frame_tick is high
// for exactly the cycle after the edge has been sampled.
//
// Ports
//   lcd_pclk    in  pixel clock
//   rst_n       in  asynchronous active-low reset
//   lcd_vs      in  vsync (same clock domain)
//   frame_tick  out one-cycle strobe per frame boundary
// ---------------------------------------------------------------------------
module lcd_frame_tick #(
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic lcd_pclk,
  input  logic rst_n,
  input  logic lcd_vs,
  output logic frame_tick
);

  // The register resets to the inactive vsync level so a vsync that is
  // already idle at reset release does not look like a boundary.
  localparam logic VS_IDLE = VS_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic r_vs;
  logic r_tick;
  logic w_edge;

  assign w_edge = VS_ACTIVE_LOW ? (r_vs & ~lcd_vs) : (~r_vs & lcd_vs);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its inputs, independent of order.
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs   <= VS_IDLE;
      r_tick <= 1'b0;
    end else begin
      r_vs   <= lcd_vs;
      r_tick <= w_edge;
    end
  end

  assign frame_tick = r_tick;

endmodule

// File: rtl/lcd_msg_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_msg_scheduler
// Chooses the status screen rendered by lcd_display. Rising edges of the
// vending-FSM event flags become pending requests; a fixed-priority arbiter
// picks the next screen, which is committed only on a frame boundary and
// held for HOLD_FRAMES frames. Error screens pre-empt non-error screens.
//
// Ports
//   lcd_pclk        in   pixel clock
//   rst_n           in   asynchronous active-low reset
//   lcd_vs          in   vsync from lcd_driver
//   product_sel     in   SELECT request (rising edge)
//   if_coin_flag    in   COIN request (rising edge)
//   if_pay_flag     in   PAY request (rising edge)
//   if_charge_flag  in   CHARGE request (rising edge)
//   nonenough_flag  in   NONENOUGH request (rising edge)
//   coin_ov_flag    in   COIN_OV request (rising edge)
//   product_number  in   product, captured at commit
//   coin_val_sum    in   coin total, captured at commit
//   msg_id          out  current screen code
//   msg_prod        out  product snapshot for current screen
//   msg_val         out  coin total snapshot for current screen
//   msg_change      out  one-cycle pulse when msg_id/msg_prod/msg_val update
//   busy            out  high while a non-IDLE screen is held
// ---------------------------------------------------------------------------
module lcd_msg_scheduler
  import lcd_msg_scheduler_pkg::*;
#(
  parameter int HOLD_FRAMES   = 120,
  parameter int CNT_W         = 8,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        lcd_vs,
  input  logic        product_sel,
  input  logic        if_coin_flag,
  input  logic        if_pay_flag,
  input  logic        if_charge_flag,
  input  logic        nonenough_flag,
  input  logic        coin_ov_flag,
  input  logic [3:0]  product_number,
  input  logic [10:0] coin_val_sum,
  output logic [2:0]  msg_id,
  output logic [3:0]  msg_prod,
  output logic [10:0] msg_val,
  output logic        msg_change,
  output logic        busy
);

  // The counter counts remaining frames after the commit tick, so it is
  // loaded with HOLD_FRAMES-1 and the screen changes on the tick that finds 0.
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_FRAMES - 1);

  logic            w_frame_tick;

  req_t            w_flags;
  req_t            r_flags_d;
  req_t            w_rise;
  req_t            r_pending;
  req_t            w_clear;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  msg_e            r_msg_id;
  logic [3:0]      r_msg_prod;
  logic [10:0]     r_msg_val;
  logic            r_msg_change;

  msg_e            w_winner;
  msg_e            w_err_winner;
  logic            w_any_pend;
  logic            w_err_pend;
  logic            w_commit;
  msg_e            w_commit_msg;
  logic            w_to_idle;

  // -------------------------------------------------------------------------
  // Frame boundary strobe
  // -------------------------------------------------------------------------
  lcd_frame_tick #(
    .VS_ACTIVE_LOW (VS_ACTIVE_LOW)
  ) u_frame_tick (
    .lcd_pclk   (lcd_pclk),
    .rst_n      (rst_n),
    .lcd_vs     (lcd_vs),
    .frame_tick (w_frame_tick)
  );

  // -------------------------------------------------------------------------
  // Flag edge detection and pending requests
  // -------------------------------------------------------------------------
  assign w_flags = {coin_ov_flag, nonenough_flag, if_charge_flag,
                    if_pay_flag, if_coin_flag, product_sel};
  assign w_rise  = w_flags & ~r_flags_d;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags_d <= '0;
      r_pending <= '0;
    end else begin
      r_flags_d <= w_flags;
      // A new edge in the same cycle as the commit of that screen survives,
      // so the request is served again later instead of being lost.
      r_pending <= (r_pending & ~w_clear) | w_rise;
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign w_winner     = pick_winner(r_pending);
  assign w_err_winner = pick_winner(r_pending & ERR_MASK);
  assign w_any_pend   = |r_pending;
  assign w_err_pend   = |(r_pending & ERR_MASK);

  // -------------------------------------------------------------------------
  // FSM next state, hold counter and commit decision
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_commit     = 1'b0;
    w_commit_msg = MSG_IDLE;
    w_to_idle    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_frame_tick && w_any_pend) begin
          w_commit     = 1'b1;
          w_commit_msg = w_winner;
          w_cnt_nxt    = HOLD_RELOAD;
          w_state_nxt  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (w_frame_tick) begin
          if (w_err_pend && !is_error(r_msg_id)) begin
            // Error pre-empts a non-error screen and restarts the hold.
            w_commit     = 1'b1;
            w_commit_msg = w_err_winner;
            w_cnt_nxt    = HOLD_RELOAD;
          end else if (r_cnt == '0) begin
            if (w_any_pend) begin
              w_commit     = 1'b1;
              w_commit_msg = w_winner;
              w_cnt_nxt    = HOLD_RELOAD;
            end else begin
              w_to_idle   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_clear = w_commit ? req_mask(w_commit_msg) : '0;

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers: screen code and snapshots change together with a
  // single msg_change pulse; the return to IDLE keeps the last snapshots.
  // -------------------------------------------------------------------------
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg_id     <= MSG_IDLE;
      r_msg_prod   <= '0;
      r_msg_val    <= '0;
      r_msg_change <= 1'b0;
    end else if (w_commit) begin
      r_msg_id     <= w_commit_msg;
      r_msg_prod   <= product_number;
      r_msg_val    <= coin_val_sum;
      r_msg_change <= 1'b1;
    end else if (w_to_idle) begin
      r_msg_id     <= MSG_IDLE;
      r_msg_change <= 1'b1;
    end else begin
      r_msg_change <= 1'b0;
    end
  end

  assign msg_id     = r_msg_id;
  assign msg_prod   = r_msg_prod;
  assign msg_val    = r_msg_val;
  assign msg_change = r_msg_change;
  // r_state updates on the same edge as r_msg_id, so busy tracks the screen.
  assign busy       = (r_state == S_SHOW);

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lcd_msg_scheduler
// Directed bench for lcd_msg_scheduler with HOLD_FRAMES=3. u_dut_lo uses a
// falling-edge vsync; u_dut_hi uses a rising-edge vsync and is held in reset
// until its own scenario. Inputs are driven and outputs sampled on negedge.
// ---------------------------------------------------------------------------
module tb_lcd_msg_scheduler;

  logic        clk;
  logic        rst_n;
  logic        rst_hi_n;
  logic        lcd_vs;
  logic        lcd_vs_hi;
  logic        product_sel;
  logic        if_coin_flag;
  logic        if_pay_flag;
  logic        if_charge_flag;
  logic        nonenough_flag;
  logic        coin_ov_flag;
  logic [3:0]  product_number;
  logic [10:0] coin_val_sum;

  logic [2:0]  msg_id,   msg_id_hi;
  logic [3:0]  msg_prod, msg_prod_hi;
  logic [10:0] msg_val,  msg_val_hi;
  logic        msg_change, msg_change_hi;
  logic        busy,     busy_hi;

  int n_compared;
  int n_mismatched;

  lcd_msg_scheduler #(.HOLD_FRAMES(3), .CNT_W(8), .VS_ACTIVE_LOW(1'b1)) u_dut_lo (
    .lcd_pclk(clk), .rst_n(rst_n), .lcd_vs(lcd_vs),
    .product_sel(product_sel), .if_coin_flag(if_coin_flag), .if_pay_flag(if_pay_flag),
    .if_charge_flag(if_charge_flag), .nonenough_flag(nonenough_flag), .coin_ov_flag(coin_ov_flag),
    .product_number(product_number), .coin_val_sum(coin_val_sum),
    .msg_id(msg_id), .msg_prod(msg_prod), .msg_val(msg_val),
    .msg_change(msg_change), .busy(busy)
  );

  lcd_msg_scheduler #(.HOLD_FRAMES(3), .CNT_W(8), .VS_ACTIVE_LOW(1'b0)) u_dut_hi (
    .lcd_pclk(clk), .rst_n(rst_hi_n), .lcd_vs(lcd_vs_hi),
    .product_sel(product_sel), .if_coin_flag(if_coin_flag), .if_pay_flag(if_pay_flag),
    .if_charge_flag(if_charge_flag), .nonenough_flag(nonenough_flag), .coin_ov_flag(coin_ov_flag),
    .product_number(product_number), .coin_val_sum(coin_val_sum),
    .msg_id(msg_id_hi), .msg_prod(msg_prod_hi), .msg_val(msg_val_hi),
    .msg_change(msg_change_hi), .busy(busy_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame boundary. The vsync pulse is one cycle wide; the commit made
  // on that boundary is visible at the negedge this task returns on.
  // coin_edge raises if_coin_flag exactly in the frame_tick cycle.
  task automatic frame(input bit hi_dut, input bit coin_edge);
    gap(2);
    if (hi_dut) lcd_vs_hi = 1'b1; else lcd_vs = 1'b0;
    @(negedge clk);
    if (hi_dut) lcd_vs_hi = 1'b0; else lcd_vs = 1'b1;
    if (coin_edge) if_coin_flag = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_lo(input string tag, input int id, input int chg, input int bsy);
    check({tag, "_id"},   32'(msg_id),     32'(id));
    check({tag, "_chg"},  32'(msg_change), 32'(chg));
    check({tag, "_busy"}, 32'(busy),       32'(bsy));
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    rst_n          = 1'b0;
    rst_hi_n       = 1'b0;
    lcd_vs         = 1'b1;
    lcd_vs_hi      = 1'b0;
    product_sel    = 1'b0;
    if_coin_flag   = 1'b0;
    if_pay_flag    = 1'b0;
    if_charge_flag = 1'b0;
    nonenough_flag = 1'b0;
    coin_ov_flag   = 1'b0;
    product_number = 4'd0;
    coin_val_sum   = 11'd0;
    gap(3);

    // Reset state
    check_lo("rst", 0, 0, 0);
    check("rst_val",  32'(msg_val),  32'd0);
    check("rst_prod", 32'(msg_prod), 32'd0);
    rst_n = 1'b1;
    gap(2);
    check("rst_rel_chg", 32'(msg_change), 32'd0);

    // 1: COIN shown for exactly 3 frames after the commit frame
    coin_val_sum   = 11'd15;
    product_number = 4'd2;
    if_coin_flag   = 1'b1;
    gap(2);
    if_coin_flag   = 1'b0;
    frame(1'b0, 1'b0);
    check_lo("t1_commit", 2, 1, 1);
    check("t1_val", 32'(msg_val), 32'd15);
    gap(1);
    check("t1_pulse_end", 32'(msg_change), 32'd0);
    frame(1'b0, 1'b0);
    check_lo("t1_hold1", 2, 0, 1);
    frame(1'b0, 1'b0);
    check_lo("t1_hold2", 2, 0, 1);
    frame(1'b0, 1'b0);
    check_lo("t1_idle", 0, 1, 0);
    check("t1_val_kept", 32'(msg_val), 32'd15);

    // 2: PAY beats SELECT; SELECT follows directly at PAY expiry
    product_number = 4'd5;
    coin_val_sum   = 11'd20;
    product_sel    = 1'b1;
    if_pay_flag    = 1'b1;
    gap(2);
    product_sel    = 1'b0;
    if_pay_flag    = 1'b0;
    frame(1'b0, 1'b0);
    check_lo("t2_pay", 3, 1, 1);
    check("t2_prod", 32'(msg_prod), 32'd5);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check_lo("t2_pay_hold", 3, 0, 1);
    frame(1'b0, 1'b0);
    check_lo("t2_select", 1, 1, 1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check_lo("t2_idle", 0, 1, 0);

    // 3: COIN_OV pre-empts SELECT; NONENOUGH waits for COIN_OV expiry
    product_sel = 1'b1;
    gap(2);
    product_sel = 1'b0;
    frame(1'b0, 1'b0);
    check_lo("t3_select", 1, 1, 1);
    coin_ov_flag = 1'b1;
    gap(2);
    coin_ov_flag = 1'b0;
    frame(1'b0, 1'b0);
    check_lo("t3_preempt", 6, 1, 1);
    nonenough_flag = 1'b1;
    gap(2);
    nonenough_flag = 1'b0;
    frame(1'b0, 1'b0);
    check_lo("t3_no_preempt", 6, 0, 1);
    frame(1'b0, 1'b0);
    check_lo("t3_ov_hold", 6, 0, 1);
    frame(1'b0, 1'b0);
    check_lo("t3_nonenough", 5, 1, 1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check_lo("t3_ne_hold", 5, 0, 1);
    frame(1'b0, 1'b0);
    check_lo("t3_idle", 0, 1, 0);

    // 4: COIN edge in the frame_tick cycle is served one frame later
    coin_val_sum = 11'd50;
    frame(1'b0, 1'b1);
    check_lo("t4_not_yet", 0, 0, 0);
    coin_val_sum = 11'd77;
    frame(1'b0, 1'b0);
    check_lo("t4_commit", 2, 1, 1);
    check("t4_val", 32'(msg_val), 32'd77);
    if_coin_flag = 1'b0;

    // 5: reset mid-hold with CHARGE pending
    if_charge_flag = 1'b1;
    gap(2);
    rst_n = 1'b0;
    #1;
    check_lo("t5_rst", 0, 0, 0);
    check("t5_rst_val", 32'(msg_val), 32'd0);
    check("t5_rst_prod", 32'(msg_prod), 32'd0);
    @(negedge clk);
    if_charge_flag = 1'b0;
    gap(2);
    rst_n = 1'b1;
    gap(1);
    check("t5_rel_chg", 32'(msg_change), 32'd0);
    for (int f = 0; f < 4; f++) begin
      frame(1'b0, 1'b0);
      check_lo($sformatf("t5_frame%0d", f), 0, 0, 0);
    end

    // 6: rising-edge vsync instance; falling edges must not tick
    rst_hi_n = 1'b1;
    gap(2);
    check("t6_rst_id", 32'(msg_id_hi), 32'd0);
    lcd_vs_hi = 1'b1;
    gap(3);
    coin_val_sum = 11'd33;
    if_coin_flag = 1'b1;
    gap(2);
    if_coin_flag = 1'b0;
    lcd_vs_hi    = 1'b0;
    gap(4);
    check("t6_fall_no_tick", 32'(msg_id_hi), 32'd0);
    frame(1'b1, 1'b0);
    check("t6_commit_id", 32'(msg_id_hi), 32'd2);
    check("t6_commit_chg", 32'(msg_change_hi), 32'd1);
    check("t6_val", 32'(msg_val_hi), 32'd33);
    check("t6_busy", 32'(busy_hi), 32'd1);
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    check("t6_hold_id", 32'(msg_id_hi), 32'd2);
    frame(1'b1, 1'b0);
    check("t6_idle_id", 32'(msg_id_hi), 32'd0);
    check("t6_idle_chg", 32'(msg_change_hi), 32'd1);
    check("t6_idle_busy", 32'(busy_hi), 32'd0);
    // The low-polarity instance saw no vsync edges during this scenario.
    check("t6_lo_untouched", 32'(msg_id), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
